serial_add_sched: RTL and testbench
===================================

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

Interface
REQ-001 Parameter W, default 4, operand and sum width in bits.
REQ-002 Parameter NREQ, fixed at 2, number of requesters sharing the serial adder.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  2  per-requester request; held high until granted.
REQ-006 a0, b0  input  W each  requester 0 operands.
REQ-007 a1, b1  input  W each  requester 1 operands.
REQ-008 gnt  output  2  one-hot grant, one-cycle pulse on the cycle the operands are sampled.
REQ-009 busy  output  1  high while an addition is in progress (SHIFT or DONE).
REQ-010 s  output  W  sum of the most recently completed addition.
REQ-011 c  output  1  carry-out of the most recently completed addition.
REQ-012 done  output  1  one-cycle pulse marking a new s/c result.
REQ-013 done_id  output  1  index of the requester whose result is on s/c.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-015 In IDLE with req != 0, the block SHALL assert gnt for the winner and capture its a/b.
  - It SHALL clear the carry flop and the bit counter.
  - It SHALL go to SHIFT.
REQ-016 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-017 Arbitration SHALL be round-robin.
  - If only one req bit is high, that requester SHALL win.
  - If both are high, the requester not served last SHALL win.
REQ-018 In SHIFT, each cycle SHALL process bit i (i = 0 to W-1, LSB first).
  - Sum bit = a[i] XOR b[i] XOR carry, shifted into the result register.
  - carry = majority(a[i], b[i], carry).
REQ-019 SHIFT SHALL last exactly W cycles; the cycle with counter = W-1 SHALL go to DONE.
REQ-020 In DONE, for one cycle, the block SHALL:
  - load s and c from the result register and carry;
  - pulse done and set done_id;
  - update the last-served pointer;
  - go to IDLE.
REQ-021 Latency: with gnt high in cycle T, done SHALL be high in cycle T+W+1 (T+5 at W=4), and the next possible grant SHALL be in cycle T+W+2.
REQ-022 The result SHALL be (a+b) mod 2^W on s, with bit W of a+b on c; there SHALL be no other width extension.
REQ-023 Requests raised while busy SHALL NOT be granted until the next IDLE cycle.
REQ-024 Operand changes after the grant cycle SHALL NOT affect the result.
REQ-025 s, c and done_id SHALL hold their value between done pulses.
REQ-026 gnt and done SHALL never be high in the same cycle.
REQ-027 gnt SHALL never have both bits high.
REQ-028 If the same requester keeps req high, it SHALL be re-granted every W+2 cycles when the other requester is idle.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL set:
  - state = IDLE; s = 0, c = 0, done = 0, done_id = 0;
  - gnt = 0, busy = 0;
  - carry, counter and result register cleared;
  - last-served pointer = 1, so requester 0 wins the first tie.
REQ-030 A reset during SHIFT or DONE SHALL abort the operation with no done pulse; the aborted request SHALL need a new grant.
REQ-031 rst SHALL take priority over every other transition in the same cycle.

Structure
REQ-032 Package serial_add_pkg SHALL hold:
  - the default W;
  - the counter width CNT_W = clog2(W);
  - the FSM state enumeration.
REQ-033 The bit-serial datapath SHALL be the sub-module serial_add_core.
  - Contents: operand shift registers, carry flop, result shift register.
  - Controls: load and shift enables from the FSM.
REQ-034 Arbitration and the FSM SHALL reside in serial_add_sched; there SHALL be no other sub-modules.

Verification
REQ-035 Reset, then req=01, a0=5, b0=3 in cycle T -> gnt=01 at T, done at T+5 with s=8, c=0, done_id=0.
REQ-036 req=10, a1=15, b1=1 -> done at T+5 with s=0, c=1, done_id=1; s/c held until the next done.
REQ-037 req=11 held continuously, first grant right after reset:
  - grants SHALL be 01, 10, 01, ... every 6 cycles;
  - done_id SHALL alternate 0, 1, 0.
REQ-038 rst pulsed in the 2nd SHIFT cycle of an a0=9, b0=9 add:
  - next cycle busy=0, s=0, c=0;
  - no done pulse;
  - a later request SHALL complete normally with s=2, c=1.
REQ-039 Requester 0 swept exhaustively over all 16x16 a0/b0 pairs -> every done SHALL give {c,s} = a0+b0, with a0/b0 changed right after each grant without affecting results.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the shared bit-serial adder: default width,
// counter sizing and the scheduler state encoding.
package serial_add_pkg;

    localparam int W_DEF = 4;

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_w(W_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial ripple adder datapath: operand shift registers, carry flop and
// result shift register. Processes one bit per shift, LSB first; after W
// shifts the result register holds the full W-bit sum.
module serial_add_core
    import serial_add_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] res_nxt,
    output logic         cy_nxt
);

    logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic         cy_q, cy_d;
    logic         sbit;

    // Full-adder on the current LSBs; res_nxt/cy_nxt are what a shift would
    // produce, so the scheduler can capture the final sum on the last shift.
    always_comb begin
        sbit    = a_q[0] ^ b_q[0] ^ cy_q;
        cy_nxt  = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);
        res_nxt = {sbit, res_q[W-1:1]};
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cy_d    = cy_q;
        if (load) begin
            a_d   = a_in;
            b_d   = b_in;
            res_d = '0;
            cy_d  = 1'b0;
        end else if (shift) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_nxt;
            cy_d  = cy_nxt;
        end
    end

    // Datapath registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            cy_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            cy_q  <= cy_d;
        end
    end

endmodule

// File: rtl/serial_add_sched.sv
// Two-requester round-robin scheduler in front of one bit-serial adder.
// Grant and operand capture happen in IDLE; W SHIFT cycles follow; the
// result is presented with a one-cycle done pulse in DONE.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [W-1:0]    a0,
    input  logic [W-1:0]    b0,
    input  logic [W-1:0]    a1,
    input  logic [W-1:0]    b1,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic [W-1:0]    s,
    output logic            c,
    output logic            done,
    output logic            done_id
);

    localparam int             CW       = cnt_w(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          cur_q, cur_d;
    logic [W-1:0]  s_q, s_d;
    logic          c_q, c_d;
    logic          id_q, id_d;
    logic          win;
    logic          load, shift;
    logic [W-1:0]  a_sel, b_sel, res_nxt;
    logic          cy_nxt;

    serial_add_core #(.W(W)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .a_in    (a_sel),
        .b_in    (b_sel),
        .res_nxt (res_nxt),
        .cy_nxt  (cy_nxt)
    );

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_q;
            default: win = 1'b0;
        endcase
        a_sel = win ? a1 : a0;
        b_sel = win ? b1 : b0;
    end

    // Next-state and control; reset suppresses grants and datapath enables.
    // s/c are captured from the core's next-shift values on the last SHIFT
    // cycle so they are already valid while done is high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cur_d   = cur_q;
        s_d     = s_q;
        c_d     = c_q;
        id_d    = id_q;
        gnt     = '0;
        load    = 1'b0;
        shift   = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req != '0) begin
                        gnt     = win ? 2'b10 : 2'b01;
                        load    = 1'b1;
                        cur_d   = win;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    shift = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        s_d     = res_nxt;
                        c_d     = cy_nxt;
                        id_d    = cur_q;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    last_d  = cur_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and result registers; pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            cur_q   <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            s_q     <= s_d;
            c_q     <= c_d;
            id_q    <= id_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign s       = s_q;
    assign c       = c_q;
    assign done_id = id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched: vector table of single additions,
// plus hand-written sequences for round-robin, busy blocking, reset abort
// and an exhaustive requester-0 sweep.
module tb_serial_add_sched;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req = 2'b00;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   gnt;
    logic         busy, c, done, done_id;
    logic [W-1:0] s;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t vecs [8];

    int gcyc [8];
    int gval [8];
    int dcyc [8];
    int did  [8];
    int ds   [8];
    int ng, nd;

    serial_add_sched #(.W(W), .NREQ(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt     (gnt),
        .busy    (busy),
        .s       (s),
        .c       (c),
        .done    (done),
        .done_id (done_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // gnt never two-hot, never together with done
    always @(negedge clk) begin
        if (!rst)
            chk("gnt_excl", 32'((gnt == 2'b11) || (done && gnt != 2'b00)), 0);
    end

    // Bounded wait for done, starting in the cycle after the grant (lat=1).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // One full transaction from the next cycle; operands scrambled after the grant.
    task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input logic ec, input string nm);
        int lat;
        @(posedge clk); #1;
        if (id) begin a1 = a; b1 = b; req = 2'b10; end
        else    begin a0 = a; b0 = b; req = 2'b01; end
        #1;
        chk({nm, "_gnt"}, 32'(gnt), id ? 2 : 1);
        @(posedge clk); #1;
        req = 2'b00;
        a0 = ~a0; b0 = b0 + 4'd3; a1 = ~a1; b1 = b1 + 4'd5;
        chk({nm, "_busy"}, 32'(busy), 1);
        wait_done(lat);
        chk({nm, "_lat"}, 32'(lat), W + 1);
        chk({nm, "_s"}, 32'(s), 32'(es));
        chk({nm, "_c"}, 32'(c), 32'(ec));
        chk({nm, "_id"}, 32'(done_id), 32'(id));
    endtask

    // Record grants and dones for ncyc cycles, cycle 0 being the current one.
    task automatic capture(input int ncyc);
        ng = 0; nd = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (gnt != 2'b00 && ng < 8) begin gcyc[ng] = k; gval[ng] = 32'(gnt); ng++; end
            if (done && nd < 8) begin dcyc[nd] = k; did[nd] = 32'(done_id); ds[nd] = 32'(s); nd++; end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W:0] sum;

        vecs[0] = '{1'b0, 4'd5,  4'd3,  4'd8,  1'b0};
        vecs[1] = '{1'b1, 4'd15, 4'd1,  4'd0,  1'b1};
        vecs[2] = '{1'b0, 4'd0,  4'd0,  4'd0,  1'b0};
        vecs[3] = '{1'b1, 4'd15, 4'd15, 4'd14, 1'b1};
        vecs[4] = '{1'b0, 4'd7,  4'd8,  4'd15, 1'b0};
        vecs[5] = '{1'b1, 4'd9,  4'd9,  4'd2,  1'b1};
        vecs[6] = '{1'b0, 4'd10, 4'd6,  4'd0,  1'b1};
        vecs[7] = '{1'b1, 4'd1,  4'd2,  4'd3,  1'b0};

        // reset state, with a request pending that must not be granted
        rst = 1'b1;
        req = 2'b11;
        a0 = 4'd3; b0 = 4'd4; a1 = 4'd6; b1 = 4'd6;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s", 32'(s), 0);
        chk("rst_c", 32'(c), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_id", 32'(done_id), 0);

        // round robin with both held: 01,10,01 every W+2 cycles
        @(posedge clk); #1;
        rst = 1'b0;
        capture(20);
        chk("rr_ng", 32'(ng >= 3), 1);
        chk("rr_g0", 32'(gval[0]), 1);
        chk("rr_g1", 32'(gval[1]), 2);
        chk("rr_g2", 32'(gval[2]), 1);
        chk("rr_c0", 32'(gcyc[0]), 0);
        chk("rr_c1", 32'(gcyc[1]), 6);
        chk("rr_c2", 32'(gcyc[2]), 12);
        chk("rr_nd", 32'(nd >= 3), 1);
        chk("rr_dc0", 32'(dcyc[0]), 5);
        chk("rr_id0", 32'(did[0]), 0);
        chk("rr_id1", 32'(did[1]), 1);
        chk("rr_id2", 32'(did[2]), 0);
        chk("rr_s0", 32'(ds[0]), 7);
        chk("rr_s1", 32'(ds[1]), 12);
        chk("rr_s2", 32'(ds[2]), 7);

        // single requester held: re-granted every W+2 cycles
        do_reset();
        a1 = 4'd2; b1 = 4'd5;
        req = 2'b10;
        capture(14);
        chk("solo_ng", 32'(ng >= 3), 1);
        chk("solo_g0", 32'(gval[0]), 2);
        chk("solo_g2", 32'(gval[2]), 2);
        chk("solo_c1", 32'(gcyc[1] - gcyc[0]), 6);
        chk("solo_c2", 32'(gcyc[2] - gcyc[1]), 6);
        chk("solo_s", 32'(ds[0]), 7);
        do_reset();

        // request raised while busy waits for the next IDLE
        @(posedge clk); #1;
        req = 2'b01; a0 = 4'd2; b0 = 4'd3; a1 = 4'd4; b1 = 4'd4;
        #1;
        chk("blk_gnt0", 32'(gnt), 1);
        @(posedge clk); #1;
        req = 2'b10;
        for (int k = 0; k < 4; k++) begin
            chk("blk_nogrant", 32'(gnt), 0);
            @(posedge clk); #1;
        end
        chk("blk_done", 32'(done), 1);
        chk("blk_s0", 32'(s), 5);
        chk("blk_id0", 32'(done_id), 0);
        chk("blk_gnt_in_done", 32'(gnt), 0);
        @(posedge clk); #1;
        chk("blk_gnt1", 32'(gnt), 2);
        @(posedge clk); #1;
        req = 2'b00;
        wait_done(lat);
        chk("blk_lat1", 32'(lat), W + 1);
        chk("blk_s1", 32'(s), 8);
        chk("blk_id1", 32'(done_id), 1);

        // vector table; results held between done pulses
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].es, vecs[i].ec, $sformatf("vec%0d", i));
            if (i == 1) begin
                repeat (3) begin @(posedge clk); #1; end
                chk("hold_s", 32'(s), 32'(vecs[i].es));
                chk("hold_c", 32'(c), 32'(vecs[i].ec));
                chk("hold_id", 32'(done_id), 1);
                chk("hold_done", 32'(done), 0);
            end
        end

        // reset in the 2nd SHIFT cycle aborts the add
        @(posedge clk); #1;
        req = 2'b01; a0 = 4'd9; b0 = 4'd9;
        #1;
        chk("abort_gnt", 32'(gnt), 1);
        @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_s", 32'(s), 0);
        chk("abort_c", 32'(c), 0);
        nd = 0;
        repeat (8) begin @(negedge clk); if (done) nd++; end
        chk("abort_nodone", 32'(nd), 0);
        run_op(1'b0, 4'd9, 4'd9, 4'd2, 1'b1, "after_abort");

        // exhaustive requester-0 sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                sum = 5'(a) + 5'(b);
                run_op(1'b0, 4'(a), 4'(b), sum[W-1:0], sum[W], "sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
